// File: rtl/crc_pkg.sv
// Shared CRC types and the width-generic CRC step used by the stream engine.
// Operands are carried at CRC_MAX_W bits so that one function serves every instance width.
package crc_pkg;

    localparam int CRC_MAX_W  = 64;
    localparam int DEF_CRC_W  = 8;
    localparam int DEF_DATA_W = 8;
    localparam int NB         = DEF_CRC_W / DEF_DATA_W;

    typedef enum logic {
        S_BODY,
        S_APPEND
    } state_t;

    // Unreflected MSB-first update: fold the beat into the top bits, then one shift per data bit.
    function automatic logic [CRC_MAX_W-1:0] crc_next(
        input logic [CRC_MAX_W-1:0] crc,
        input logic [CRC_MAX_W-1:0] data,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   crc_w,
        input int                   data_w
    );
        logic [CRC_MAX_W-1:0] c;
        logic [CRC_MAX_W-1:0] mask;
        mask = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - crc_w);
        c    = (crc ^ (data << (crc_w - data_w))) & mask;
        for (int i = 0; i < CRC_MAX_W; i++) begin
            if (i < data_w) begin
                if (c[crc_w-1]) begin
                    c = ((c << 1) ^ poly) & mask;
                end else begin
                    c = (c << 1) & mask;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational single-beat CRC update for one instance width.
module crc_step
    import crc_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = 'hCF
) (
    input  logic [CRC_W-1:0]  crc_cur,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_nxt
);

    assign crc_nxt = CRC_W'(crc_next(CRC_MAX_W'(crc_cur), CRC_MAX_W'(data),
                                     CRC_MAX_W'(POLY), CRC_W, DATA_W));

endmodule

// File: rtl/crc_stream.sv
// Inline CRC engine on a valid/ready beat stream: GEN appends the CRC, CHK verifies the residue.
// One registered output stage; in_ready drops while the CRC trailer is being emitted.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] POLY     = 'hCF,
    parameter logic [CRC_W-1:0] INIT     = 'hFF,
    parameter int               CHECK    = 0,
    parameter int               ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic                chk_valid,
    output logic                chk_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int N_BEATS = CRC_W / DATA_W;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    generate
        if (CRC_W % DATA_W != 0) begin : g_bad_width
            $fatal(1, "crc_stream: CRC_W must be a multiple of DATA_W");
        end
        if (CRC_W > CRC_MAX_W) begin : g_too_wide
            $fatal(1, "crc_stream: CRC_W exceeds CRC_MAX_W");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CRC_W-1:0]    crc_q, crc_d, crc_nxt;
    logic [DATA_W-1:0]   out_data_d, chunk;
    logic                out_valid_d, out_last_d;
    logic                chk_valid_d, chk_err_d;
    logic [ERRCNT_W-1:0] err_cnt_d;
    logic                load, acc;

    crc_step #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY)) u_step (
        .crc_cur (crc_q),
        .data    (in_data),
        .crc_nxt (crc_nxt)
    );

    assign load     = !out_valid || out_ready;
    assign in_ready = (state_q == S_BODY) && load;
    assign acc      = in_valid && in_ready;
    // Trailer goes out most significant chunk first.
    assign chunk    = DATA_W'(crc_q >> ((N_BEATS - 1 - int'(cnt_q)) * DATA_W));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        chk_valid_d = 1'b0;
        chk_err_d   = chk_err;
        err_cnt_d   = err_cnt;
        case (state_q)
            S_BODY: begin
                if (load) begin
                    out_valid_d = acc;
                    if (acc) begin
                        out_data_d = in_data;
                        out_last_d = (CHECK != 0) ? in_last : 1'b0;
                        crc_d      = crc_nxt;
                        if (in_last) begin
                            if (CHECK != 0) begin
                                crc_d       = INIT;
                                chk_valid_d = 1'b1;
                                chk_err_d   = (crc_nxt != '0);
                                if ((crc_nxt != '0) && (err_cnt != '1)) begin
                                    err_cnt_d = err_cnt + 1'b1;
                                end
                            end else begin
                                state_d = S_APPEND;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
            end
            S_APPEND: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = chunk;
                    out_last_d  = (cnt_q == CNT_W'(N_BEATS - 1));
                    if (cnt_q == CNT_W'(N_BEATS - 1)) begin
                        state_d = S_BODY;
                        cnt_d   = '0;
                        crc_d   = INIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_BODY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BODY;
            cnt_q     <= '0;
            crc_q     <= INIT;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            chk_valid <= 1'b0;
            chk_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            chk_valid <= chk_valid_d;
            chk_err   <= chk_err_d;
            err_cnt   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: one GEN instance and one CHK instance (2-bit error counter),
// checked against a polynomial long-division reference model.
module tb_crc_stream;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        g_rst, g_in_valid, g_in_last, g_in_ready, g_out_valid, g_out_last, g_out_ready;
    logic        g_chk_valid, g_chk_err;
    logic [7:0]  g_in_data, g_out_data;
    logic [15:0] g_err_cnt;
    logic        c_rst, c_in_valid, c_in_last, c_in_ready, c_out_valid, c_out_last, c_out_ready;
    logic        c_chk_valid, c_chk_err;
    logic [7:0]  c_in_data, c_out_data;
    logic [1:0]  c_err_cnt;

    crc_stream #(.CHECK(0)) u_gen (
        .clk(clk), .rst(g_rst), .in_data(g_in_data), .in_valid(g_in_valid), .in_last(g_in_last),
        .in_ready(g_in_ready), .out_data(g_out_data), .out_valid(g_out_valid), .out_last(g_out_last),
        .out_ready(g_out_ready), .chk_valid(g_chk_valid), .chk_err(g_chk_err), .err_cnt(g_err_cnt)
    );

    crc_stream #(.CHECK(1), .ERRCNT_W(2)) u_chk (
        .clk(clk), .rst(c_rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_last(c_out_last),
        .out_ready(c_out_ready), .chk_valid(c_chk_valid), .chk_err(c_chk_err), .err_cnt(c_err_cnt)
    );

    int    tests = 0;
    int    fails = 0;
    beat_t g_q[$];
    beat_t c_q[$];
    bit    e_q[$];
    int    err_model = 0;
    int    g_mode = 0;
    int    c_mode = 0;
    logic [7:0] init_v = 8'hFF;
    logic [8:0] gen_poly = 9'h1CF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Remainder of (message with INIT folded into its leading bits) * x^8 modulo x^8+x^7+x^6+x^3+x^2+x+1.
    function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
        bit         b[$];
        logic [7:0] r;
        foreach (msg[k]) for (int i = 7; i >= 0; i--) b.push_back(msg[k][i]);
        for (int i = 0; i < 8; i++) b[i] ^= init_v[7-i];
        repeat (8) b.push_back(1'b0);
        for (int i = 0; i + 8 < b.size(); i++)
            if (b[i]) for (int j = 0; j < 9; j++) b[i+j] ^= gen_poly[8-j];
        for (int i = 0; i < 8; i++) r[7-i] = b[b.size()-8+i];
        return r;
    endfunction

    initial begin
        g_out_ready = 1'b1;
        c_out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (g_mode)
                0:       g_out_ready = 1'b1;
                1:       g_out_ready = ~g_out_ready;
                default: g_out_ready = 1'($urandom_range(0, 1));
            endcase
            c_out_ready = (c_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // GEN output monitor: pops expectations on each handshake and checks hold-while-stalled.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        beat_t      e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall && !g_rst) begin
                check("gen_hold_valid", 32'(g_out_valid), 32'd1);
                check("gen_hold_beat", {g_out_data, g_out_last}, {prev_d, prev_l});
            end
            if (g_out_valid && g_out_ready) begin
                if (g_q.size() == 0) flag("gen_unexpected_beat");
                else begin
                    e = g_q.pop_front();
                    check("gen_beat", {g_out_data, g_out_last}, {e.data, e.last});
                end
            end
            prev_stall = g_out_valid && !g_out_ready && !g_rst;
            prev_d = g_out_data;
            prev_l = g_out_last;
        end
    end

    // CHK monitor: forwarded beats plus the residue pulse and error counter.
    initial begin
        beat_t e;
        bit    bad;
        forever begin
            @(negedge clk);
            if (c_out_valid && c_out_ready) begin
                if (c_q.size() == 0) flag("chk_unexpected_beat");
                else begin
                    e = c_q.pop_front();
                    check("chk_beat", {c_out_data, c_out_last}, {e.data, e.last});
                end
            end
            if (c_chk_valid) begin
                if (e_q.size() == 0) flag("chk_unexpected_pulse");
                else begin
                    bad = e_q.pop_front();
                    if (bad && err_model < 3) err_model++;
                    check("chk_err", 32'(c_chk_err), 32'(bad));
                    check("chk_err_cnt", 32'(c_err_cnt), 32'(err_model));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input bit to_chk, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        if (to_chk) begin
            c_in_data = d; c_in_last = l; c_in_valid = 1'b1;
        end else begin
            g_in_data = d; g_in_last = l; g_in_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(to_chk ? c_in_ready : g_in_ready) && n < 300);
        if (n >= 300) flag("in_ready_timeout");
        @(posedge clk); #1;
        if (to_chk) c_in_valid = 1'b0;
        else        g_in_valid = 1'b0;
    endtask

    task automatic gen_pkt(input logic [7:0] msg[$]);
        foreach (msg[k]) g_q.push_back('{data: msg[k], last: 1'b0});
        g_q.push_back('{data: model_crc(msg), last: 1'b1});
        foreach (msg[k]) send(1'b0, msg[k], k == msg.size() - 1);
    endtask

    task automatic chk_pkt(input logic [7:0] msg[$], input bit corrupt);
        logic [7:0] full[$];
        full = msg;
        full.push_back(model_crc(msg) ^ (corrupt ? 8'($urandom_range(1, 255)) : 8'h00));
        foreach (full[k]) c_q.push_back('{data: full[k], last: k == full.size() - 1});
        e_q.push_back(model_crc(full) != 8'h00);
        foreach (full[k]) send(1'b1, full[k], k == full.size() - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((g_q.size() != 0 || c_q.size() != 0 || e_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) flag("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pkt[$];
        g_rst = 1'b1; c_rst = 1'b1;
        g_in_valid = 1'b0; g_in_last = 1'b0; g_in_data = '0;
        c_in_valid = 1'b0; c_in_last = 1'b0; c_in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(g_out_valid), 32'd0);
        check("rst_out_last", 32'(g_out_last), 32'd0);
        check("rst_out_data", 32'(g_out_data), 32'd0);
        check("rst_chk_valid", 32'(c_chk_valid), 32'd0);
        check("rst_chk_err", 32'(c_chk_err), 32'd0);
        check("rst_err_cnt", 32'(c_err_cnt), 32'd0);
        check("rst_gen_err_cnt", 32'(g_err_cnt), 32'd0);
        @(posedge clk); #1;
        g_rst = 1'b0; c_rst = 1'b0;

        // Single zero beat: trailer 8'hD2, one cycle of in_ready low.
        pkt = '{8'h00};
        gen_pkt(pkt);
        @(negedge clk);
        check("t1_in_ready_low", 32'(g_in_ready), 32'd0);
        @(negedge clk);
        check("t1_in_ready_back", 32'(g_in_ready), 32'd1);
        check("t1_crc_beat", {g_out_data, g_out_last}, {8'hD2, 1'b1});
        @(posedge clk); #1;
        drain();

        // Good then bad residue.
        pkt = '{8'h00, 8'hD2};
        c_q.push_back('{data: 8'h00, last: 1'b0});
        c_q.push_back('{data: 8'hD2, last: 1'b1});
        e_q.push_back(model_crc(pkt) != 8'h00);
        send(1'b1, 8'h00, 1'b0);
        send(1'b1, 8'hD2, 1'b1);
        drain();
        check("t2_good_cnt", 32'(c_err_cnt), 32'd0);
        pkt = '{8'h00, 8'hD3};
        c_q.push_back('{data: 8'h00, last: 1'b0});
        c_q.push_back('{data: 8'hD3, last: 1'b1});
        e_q.push_back(model_crc(pkt) != 8'h00);
        send(1'b1, 8'h00, 1'b0);
        send(1'b1, 8'hD3, 1'b1);
        drain();
        check("t2_bad_cnt", 32'(c_err_cnt), 32'd1);

        // Alternating backpressure on a 3-beat packet.
        g_mode = 1;
        pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
        gen_pkt(pkt);
        drain();

        // Back-to-back zero packets: INIT must reload between them.
        g_mode = 0;
        @(posedge clk); #1;
        pkt = '{8'h00};
        gen_pkt(pkt);
        gen_pkt(pkt);
        drain();

        // Reset while the trailer is pending: only the data beat may appear.
        g_q.push_back('{data: 8'h00, last: 1'b0});
        send(1'b0, 8'h00, 1'b1);
        g_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("t5_out_valid_after_rst", 32'(g_out_valid), 32'd0);
        @(posedge clk); #1;
        g_rst = 1'b0;
        pkt = '{8'h00};
        gen_pkt(pkt);
        drain();

        // Random packets on both instances under random backpressure.
        g_mode = 2;
        c_mode = 1;
        for (int p = 0; p < 20; p++) begin
            pkt = {};
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) pkt.push_back(8'($urandom));
            gen_pkt(pkt);
            chk_pkt(pkt, 1'($urandom_range(0, 1)));
        end
        drain();

        // Counter saturation.
        c_mode = 0;
        for (int p = 0; p < 5; p++) begin
            pkt = '{8'($urandom), 8'($urandom)};
            chk_pkt(pkt, 1'b1);
        end
        drain();
        check("t6_err_cnt_sat", 32'(c_err_cnt), 32'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_err_cnt_hold", 32'(c_err_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
